// File: rtl/mac_acc_tc_32_pkg.sv
// Shared types for the signed multiply-accumulate back end.
package mac_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PROD_W = 32;

endpackage

// File: rtl/mac_acc_tc_32_if.sv
// Term-in / result-out handshake bundle for mac_acc_tc_32.
interface mac_acc_tc_32_if #(
    parameter int ACC_W = 40
);
    logic                                    start;
    logic                                    in_valid;
    logic                                    in_ready;
    logic signed [mac_acc_pkg::PROD_W-1:0]   product;
    logic                                    out_valid;
    logic                                    out_ready;
    logic signed [ACC_W-1:0]                 acc;
    logic                                    sat;

    modport master (
        output start, in_valid, product, out_ready,
        input  in_ready, out_valid, acc, sat
    );

    modport slave (
        input  start, in_valid, product, out_ready,
        output in_ready, out_valid, acc, sat
    );
endinterface

// File: rtl/mac_acc_tc_32_sat_add.sv
// Signed saturating adder: ACC_W accumulator plus ACC_W+1 sign-extended term.
// Purely combinational; clamps to the ACC_W signed range and flags overflow.
module sat_add #(
    parameter int ACC_W = 40
) (
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W:0]   b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    ovf_o
);
    localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] wide;

    // Term fits in ACC_W bits, so the ACC_W+1 sum never wraps; the top two
    // bits disagreeing is exactly the out-of-range condition.
    assign wide  = {a_i[ACC_W-1], a_i} + b_i;
    assign ovf_o = wide[ACC_W] ^ wide[ACC_W-1];

    always_comb begin
        sum_o = wide[ACC_W-1:0];
        if (ovf_o) begin
            sum_o = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end
endmodule

// File: rtl/mac_acc_tc_32.sv
// Dot-product engine: sums N_TERMS signed 32-bit terms into a saturating accumulator.
// One term per cycle; result held in DONE until out_ready, start+out_ready chains the next run.
module mac_acc_tc_32
    import mac_acc_pkg::*;
#(
    parameter int N_TERMS = 16,
    parameter int ACC_W   = 40
) (
    input  logic           clk,
    input  logic           rst,
    mac_acc_tc_32_if.slave bus
);
    localparam int CNT_W = $clog2(N_TERMS + 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    sat_q;
    logic                    sat_d;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    ovf;
    logic signed [ACC_W:0]   prod_ext;

    assign prod_ext = {{(ACC_W + 1 - PROD_W){bus.product[PROD_W-1]}}, bus.product};

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (acc_d),
        .ovf_o (ovf)
    );

    assign cnt_d = cnt_q + CNT_W'(1);
    assign sat_d = sat_q | ovf;

    // Handshake outputs are flops that change only with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_ACC;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        sat_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_W'(N_TERMS)) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.start) begin
                            state_q    <= ST_ACC;
                            cnt_q      <= '0;
                            acc_q      <= '0;
                            sat_q      <= 1'b0;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc       = acc_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_mac_acc_tc_32.sv
// Directed bench: a 40-bit instance for function/handshake, a 32-bit instance for clamping.
module tb_mac_acc_tc_32;
    import mac_acc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mac_acc_tc_32_if #(.ACC_W(40)) ifa ();
    mac_acc_tc_32_if #(.ACC_W(32)) ifs ();

    mac_acc_tc_32 #(.N_TERMS(4), .ACC_W(40)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mac_acc_tc_32 #(.N_TERMS(4), .ACC_W(32)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.product = '0; ifa.out_ready = 1'b0;
        ifs.start = 1'b0; ifs.in_valid = 1'b0; ifs.product = '0; ifs.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_acc", ifa.acc, 0);
        chk("rst_sat", ifa.sat, 0);
        rst = 1'b0;

        // Sign mix on consecutive cycles
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("mix_in_ready", ifa.in_ready, 1);
        ifa.in_valid = 1'b1;
        ifa.product = 32'sd6;   tick();
        ifa.product = -32'sd2;  tick();
        ifa.product = 32'sd100; tick();
        chk("mix_ov_early", ifa.out_valid, 0);
        ifa.product = -32'sd4;  tick();
        chk("mix_out_valid", ifa.out_valid, 1);
        chk("mix_in_ready_done", ifa.in_ready, 0);
        chk("mix_acc", ifa.acc, 64'sd100);
        chk("mix_sat", ifa.sat, 0);

        // Backpressure in DONE with a term offered
        ifa.product = 32'sd999;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_acc", ifa.acc, 64'sd100);
            chk("bp_in_ready", ifa.in_ready, 0);
            chk("bp_out_valid", ifa.out_valid, 1);
        end
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        chk("idle_out_valid", ifa.out_valid, 0);
        chk("idle_in_ready", ifa.in_ready, 0);
        chk("idle_acc_hold", ifa.acc, 64'sd100);

        // Bubbles of 0/3/1 cycles between terms
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.product = 32'sd6;  tick();
        ifa.product = -32'sd2; tick();
        chk("bub_cnt2", dut_a.cnt_q, 2);
        chk("bub_acc2", ifa.acc, 64'sd4);
        ifa.in_valid = 1'b0;
        ifa.product = 32'sd12345;
        tick(); tick(); tick();
        chk("bub_cnt_gap", dut_a.cnt_q, 2);
        chk("bub_acc_gap", ifa.acc, 64'sd4);
        chk("bub_in_ready", ifa.in_ready, 1);
        ifa.in_valid = 1'b1;
        ifa.product = 32'sd100; tick();
        ifa.in_valid = 1'b0;
        tick();
        chk("bub_cnt3", dut_a.cnt_q, 3);
        chk("bub_acc3", ifa.acc, 64'sd104);
        ifa.in_valid = 1'b1;
        ifa.product = -32'sd4; tick();
        ifa.in_valid = 1'b0;
        chk("bub_acc", ifa.acc, 64'sd100);
        chk("bub_out_valid", ifa.out_valid, 1);
        chk("bub_sat", ifa.sat, 0);

        // Back-to-back: start with out_ready in DONE
        ifa.start = 1'b1;
        ifa.out_ready = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifa.out_ready = 1'b0;
        chk("b2b_state", dut_a.state_q, ST_ACC);
        chk("b2b_in_ready", ifa.in_ready, 1);
        chk("b2b_out_valid", ifa.out_valid, 0);
        chk("b2b_acc", ifa.acc, 0);
        chk("b2b_sat", ifa.sat, 0);

        // Start held high during ACC is ignored; reset after two accepts
        ifa.start = 1'b1;
        ifa.in_valid = 1'b1;
        ifa.product = 32'sd1;
        tick(); tick();
        chk("mid_acc2", ifa.acc, 64'sd2);
        ifa.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_acc", ifa.acc, 0);
        chk("mid_rst_in_ready", ifa.in_ready, 0);
        chk("mid_rst_out_valid", ifa.out_valid, 0);
        chk("mid_rst_sat", ifa.sat, 0);
        chk("mid_rst_cnt", dut_a.cnt_q, 0);
        rst = 1'b0;
        tick();
        chk("restart_in_ready", ifa.in_ready, 1);
        ifa.in_valid = 1'b1;
        ifa.product = 32'sd1;
        tick(); tick(); tick(); tick();
        ifa.in_valid = 1'b0;
        chk("restart_acc", ifa.acc, 64'sd4);
        chk("restart_out_valid", ifa.out_valid, 1);
        tick(); tick();
        chk("done_start_ignored_ov", ifa.out_valid, 1);
        chk("done_start_ignored_acc", ifa.acc, 64'sd4);
        ifa.start = 1'b0;
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        chk("restart_release", ifa.out_valid, 0);

        // Positive saturation on the 32-bit instance
        ifs.start = 1'b1;
        tick();
        ifs.start = 1'b0;
        ifs.in_valid = 1'b1;
        ifs.product = 32'sh40000000;
        tick();
        chk("psat_acc1", ifs.acc, 32'sh40000000);
        chk("psat_sat1", ifs.sat, 0);
        tick();
        chk("psat_acc2", ifs.acc, 32'sh7FFFFFFF);
        chk("psat_sat2", ifs.sat, 1);
        tick(); tick();
        ifs.in_valid = 1'b0;
        chk("psat_acc", ifs.acc, 32'sh7FFFFFFF);
        chk("psat_sat", ifs.sat, 1);
        chk("psat_out_valid", ifs.out_valid, 1);

        // Chain straight into negative saturation
        ifs.start = 1'b1;
        ifs.out_ready = 1'b1;
        tick();
        ifs.start = 1'b0;
        ifs.out_ready = 1'b0;
        chk("nsat_clr_acc", ifs.acc, 0);
        chk("nsat_clr_sat", ifs.sat, 0);
        chk("nsat_in_ready", ifs.in_ready, 1);
        ifs.in_valid = 1'b1;
        ifs.product = 32'shC0000000;
        tick(); tick();
        chk("nsat_acc2", ifs.acc, 32'sh80000000);
        chk("nsat_sat2", ifs.sat, 0);
        tick(); tick();
        ifs.in_valid = 1'b0;
        chk("nsat_acc", ifs.acc, 32'sh80000000);
        chk("nsat_sat", ifs.sat, 1);
        chk("nsat_out_valid", ifs.out_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_acc_tc_32.md
# mac_acc_tc_32

Sequential signed multiply-accumulate back end that sits directly downstream of `mul_tc_16_16`. It consumes the 32-bit two's-complement `product` stream one term per valid/ready handshake and sums exactly `N_TERMS` terms into a saturating accumulator. It then presents the dot-product result on a valid/ready output port. It turns the combinational 16x16 multiplier into a complete dot-product engine.

## Interface
- `N_TERMS`, default 16: terms per dot product; must be ≥ 1.
- `ACC_W`, default 40: accumulator width; must be ≥ 32; signed.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start`  in  1  begin a new dot product; sampled in IDLE, and in DONE only together with `out_ready`.
- `in_valid`  in  1  `product` carries a term.
- `in_ready`  out  1  block accepts a term this cycle.
- `product`  in  32  signed term, taken from `mul_tc_16_16.product`.
- `out_valid`  out  1  `acc` holds a finished result.
- `out_ready`  in  1  consumer takes the result.
- `acc`  out  ACC_W  signed accumulator / result.
- `sat`  out  1  sticky flag: saturation occurred in the current dot product.

## Operation
- States:
  - IDLE: `in_ready`=0, `out_valid`=0.
  - ACC: `in_ready`=1.
  - DONE: `out_valid`=1, `in_ready`=0.
- IDLE & `start` → ACC. On the same edge, `acc`←0, `sat`←0 and term counter `cnt`←0.
- ACC: a term is accepted when `in_valid & in_ready`.
  - Sign-extend `product` to ACC_W+1 bits and add it to `acc`.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to that value and set `sat`. If it is below -2^(ACC_W-1), clamp to that value and set `sat`.
  - `cnt` increments on each accept.
  - The accept that makes `cnt`=N_TERMS moves to DONE.
- `in_valid` low in ACC: nothing changes. Bubbles are unlimited.
- DONE: `acc` and `sat` are held stable until `out_ready`.
  - `out_ready` & !`start` → IDLE.
  - `out_ready` & `start` → ACC with clear, giving back-to-back dot products with no IDLE cycle.
- `start` in ACC is ignored. `start` in DONE without `out_ready` is ignored, not queued.
- `in_valid` outside ACC is ignored. `product` is don't-care whenever `in_valid`=0.
- `acc` in IDLE holds the last result (0 after reset).
- `cnt` width is clog2(N_TERMS+1).

## Timing
- Reset values: state IDLE, `acc`=0, `sat`=0, `cnt`=0, `in_ready`=0, `out_valid`=0. All are applied asynchronously on `rst` rise.
- `rst` mid-operation discards the partial sum. The next `start` after `rst` falls begins cleanly.
- `in_ready` and `out_valid` are pure decodes of registered state, with no combinational path from inputs.
- Latency:
  - `in_ready` rises the cycle after the `start` edge.
  - `out_valid` rises the cycle after the N-th accept.
  - Minimum start-to-result time is N_TERMS+1 cycles.
- Throughput: one term per cycle. Back-to-back dot products cost one DONE cycle each.

## Structure
- Package `mac_acc_pkg`: state encoding (IDLE, ACC, DONE) and `PROD_W`=32.
- Sub-module `sat_add`: parameterised ACC_W signed saturating adder. Inputs are `acc` and the sign-extended product; outputs are the clamped sum and an overflow flag.
- Top level holds the FSM, `cnt`, `acc` and `sat` registers.

## Test plan
- Sign mix: N_TERMS=4, reset, `start`, products 6, -2, 100, -4 on consecutive cycles → `acc`=100, `sat`=0, `out_valid` high one cycle after the 4th accept.
- Bubbles: same four terms with `in_valid` gaps of 0/3/1 cycles → same result; `cnt` advances only on handshakes.
- Backpressure: `out_ready` low for 5 cycles in DONE, `in_valid`=1 with value 999 → `acc`=100 stable, `in_ready`=0, the term is not absorbed.
- Saturation: ACC_W=32, N_TERMS=4.
  - Products 0x40000000 ×4 → `acc`=0x7FFFFFFF, `sat`=1.
  - Products 0xC0000000 ×4 → `acc`=0x80000000, `sat`=1.
- Reset mid-operation: `rst` pulse after 2 accepts → all outputs at reset values immediately. A new `start` with terms 1, 1, 1, 1 → `acc`=4.
- Back-to-back: `start` and `out_ready` together in DONE → next cycle state ACC, `acc`=0, `sat`=0, `in_ready`=1.
